// File: rtl/uart_mmio_pkg.sv
// Shared constants and types for the MMIO UART controller.
// Holds register addresses, CON bit positions and the TX FSM states.
package uart_mmio_pkg;

  localparam logic [31:0] ADDR_TXD_DEF = 32'h4000_0018;
  localparam logic [31:0] ADDR_RXD_DEF = 32'h4000_001C;
  localparam logic [31:0] ADDR_CON_DEF = 32'h4000_0020;

  localparam int CON_IRQ_EN  = 0;
  localparam int CON_TX_IDLE = 1;
  localparam int CON_TX_FULL = 2;
  localparam int CON_RX_NE   = 3;
  localparam int CON_RX_OVF  = 4;
  localparam int CON_TX_DROP = 5;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT,
    TX_BUSY
  } tx_state_t;

endpackage

// File: rtl/uart_mmio_ctrl_fifo.sv
// byte_fifo: DEPTH-entry 8-bit FIFO with combinational head output.
// Ports: push/din write, pop reads dout, full/empty flags, async low reset.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  // A pop frees the slot the push lands in, so full+pop+push is accepted.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_d = rd_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO UART controller: TX/RX FIFOs, CON register and TX handshake FSM.
// Ports: MEM-stage bus (Addr/WriteData/MemRd/MemWr/ReadData/Hit), UART side, IRQ.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter int          BUSY_TIMEOUT = 16,
  parameter logic [31:0] ADDR_TXD     = ADDR_TXD_DEF,
  parameter logic [31:0] ADDR_RXD     = ADDR_RXD_DEF,
  parameter logic [31:0] ADDR_CON     = ADDR_CON_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemRd,
  input  logic        MemWr,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic [7:0]  UART_TXD,
  output logic        TX_EN,
  input  logic        TX_STATUS,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_STATUS,
  output logic        IRQ
);

  localparam int CW = $clog2(BUSY_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  logic hit_txd, hit_rxd, hit_con;
  logic wr_txd, wr_con, rd_rxd;

  logic [7:0] tx_head, rx_head;
  logic       tx_full, tx_empty, tx_pop;
  logic       rx_full, rx_empty, rx_pop;

  tx_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]  txd_q, txd_d;

  logic irq_en_q, irq_en_d;
  logic rx_ovf_q, rx_ovf_d;
  logic tx_drop_q, tx_drop_d;
  logic irq_q, irq_d;
  logic rx_ovf_set, tx_drop_set;
  logic tx_idle;
  logic [31:0] con_val;
  logic unused_wdata;

  assign hit_txd = (Addr == ADDR_TXD);
  assign hit_rxd = (Addr == ADDR_RXD);
  assign hit_con = (Addr == ADDR_CON);
  assign Hit     = hit_txd | hit_rxd | hit_con;

  assign wr_txd = MemWr & hit_txd;
  assign wr_con = MemWr & hit_con;
  assign rd_rxd = MemRd & hit_rxd;
  assign rx_pop = rd_rxd;

  assign unused_wdata = ^{WriteData[31:8]};

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txd),
    .pop   (tx_pop),
    .din   (WriteData[7:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (RX_STATUS),
    .pop   (rx_pop),
    .din   (RX_DATA),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign tx_idle = tx_empty & (state_q == TX_IDLE);

  always_comb begin
    con_val              = '0;
    con_val[CON_IRQ_EN]  = irq_en_q;
    con_val[CON_TX_IDLE] = tx_idle;
    con_val[CON_TX_FULL] = tx_full;
    con_val[CON_RX_NE]   = ~rx_empty;
    con_val[CON_RX_OVF]  = rx_ovf_q;
    con_val[CON_TX_DROP] = tx_drop_q;
  end

  always_comb begin
    ReadData = '0;
    if (MemRd) begin
      unique case (1'b1)
        hit_rxd: ReadData = rx_empty ? 32'h0 : {24'h0, rx_head};
        hit_con: ReadData = con_val;
        default: ReadData = '0;
      endcase
    end
  end

  // Drops only count when no same-cycle pop frees a slot.
  assign rx_ovf_set  = RX_STATUS & rx_full & ~(rx_pop & ~rx_empty);
  assign tx_drop_set = wr_txd & tx_full & ~tx_pop;

  always_comb begin
    irq_en_d  = wr_con ? WriteData[CON_IRQ_EN] : irq_en_q;
    rx_ovf_d  = (rx_ovf_q & ~(wr_con & WriteData[CON_RX_OVF]))
              | rx_ovf_set;
    tx_drop_d = (tx_drop_q & ~(wr_con & WriteData[CON_TX_DROP]))
              | tx_drop_set;
    irq_d     = irq_en_q & ~rx_empty;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txd_d   = txd_q;
    tx_pop  = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!tx_empty && TX_STATUS) state_d = TX_SEND;
      end
      TX_SEND: begin
        tx_pop  = 1'b1;
        txd_d   = tx_head;
        cnt_d   = '0;
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (!TX_STATUS)           state_d = TX_BUSY;
        else if (cnt_q == CNT_LAST) state_d = TX_IDLE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      TX_BUSY: begin
        if (TX_STATUS) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      txd_q     <= '0;
      irq_en_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_drop_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      txd_q     <= txd_d;
      irq_en_q  <= irq_en_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_drop_q <= tx_drop_d;
      irq_q     <= irq_d;
    end
  end

  assign TX_EN    = (state_q == TX_SEND);
  assign UART_TXD = TX_EN ? tx_head : txd_q;
  assign IRQ      = irq_q;

endmodule
